sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of cycles each SRAM access holds the bus; legal range is 1..7.
REQ-002 Ports SHALL be as follows. There is one clock. Reset is synchronous and active-high. The clock port is named clk and the reset port is named rst.
  clk          in   1   sole clock, rising edge
  rst          in   1   synchronous active-high reset
  if_req       in   1   instruction fetch request, held until if_gnt
  if_addr      in   32  fetch byte address
  if_gnt       out  1   fetch accepted this cycle (combinational)
  if_ack       out  1   one-cycle pulse, if_rdata valid
  if_rdata     out  32  fetched instruction word
  d_req        in   1   data request, held until d_gnt
  d_we         in   1   1 = store, 0 = load
  d_be         in   4   byte enables, active-high
  d_addr       in   32  data byte address
  d_wdata      in   32  store data
  d_gnt        out  1   data accepted this cycle (combinational)
  d_ack        out  1   one-cycle pulse, access complete
  d_rdata      out  32  load data, valid with d_ack on loads
  busy         out  1   state != IDLE
  sram_addr    out  20  word address
  sram_ce_n    out  1   chip enable, active-low
  sram_oe_n    out  1   output enable, active-low
  sram_we_n    out  1   write enable, active-low
  sram_be_n    out  4   byte enables, active-low
  sram_wdata   out  32  write data
  sram_wdata_oe out 1   1 = drive sram_wdata onto the bus
  sram_rdata   in   32  read data from SRAM

Function
REQ-003 The FSM states SHALL be IDLE, D_ACC, I_ACC and DONE.
REQ-004 In IDLE, d_gnt SHALL equal d_req, and if_gnt SHALL equal if_req & ~d_req, so data has fixed priority; in every other state both grants SHALL be 0.
REQ-005 On a grant, the arbiter SHALL latch the address, we, be and wdata, load the wait counter with WAIT_CYCLES-1, and enter D_ACC or I_ACC.
REQ-006 In D_ACC and I_ACC, the arbiter SHALL drive the latched address bits [21:2] onto sram_addr and set sram_ce_n=0.
REQ-007 In D_ACC and I_ACC, loads and fetches SHALL set sram_oe_n=0, sram_we_n=1, sram_wdata_oe=0 and sram_be_n = ~be (fetch uses be=4'hF).
REQ-008 In D_ACC, stores SHALL set sram_oe_n=1, sram_we_n=0, sram_wdata_oe=1 and sram_be_n=~be.
REQ-009 The counter SHALL decrement each access cycle; when it is 0, the arbiter SHALL capture sram_rdata (reads only) and enter DONE.
REQ-010 The total access SHALL be exactly WAIT_CYCLES cycles.
REQ-011 DONE SHALL last one cycle, assert exactly one of if_ack or d_ack, then return to IDLE.
REQ-012 Latency: a grant in cycle N SHALL give an ack in cycle N+WAIT_CYCLES+1; the next grant is possible in cycle N+WAIT_CYCLES+2.
REQ-013 if_rdata and d_rdata SHALL hold their last captured value until the next read of the same port completes; stores SHALL NOT change d_rdata.
REQ-014 Outside D_ACC and I_ACC, the SRAM outputs SHALL be: ce_n/oe_n/we_n=1, be_n=4'hF, wdata_oe=0 and addr held.
REQ-015 Requests SHALL be ignored outside IDLE; a requester whose request is ignored keeps it asserted.
REQ-016 When if_req and d_req rise in the same IDLE cycle, data SHALL be served first and the fetch granted in the IDLE cycle following data DONE.
REQ-017 Address bits [1:0] and [31:22] SHALL be ignored.
REQ-018 busy SHALL be 1 in D_ACC, I_ACC and DONE.

Reset
REQ-019 rst sampled high SHALL, at that edge, force IDLE, counter 0, all acks 0, if_rdata=d_rdata=0, sram_addr=0 and SRAM controls inactive per REQ-014, including mid-access.
REQ-020 An access in flight at reset SHALL be abandoned with no ack.
REQ-021 Grants SHALL be 0 while rst is high.

Structure
REQ-022 The state enumeration, WAIT_CYCLES default and SRAM address width (20) SHALL live in the shared CPU package.
REQ-023 The down-counter SHALL be one sub-module, arb_wait_counter (load, decrement, zero flag); the FSM and datapath stay in sram_arbiter.

Verification
REQ-024 The bench SHALL cover the following directed scenarios, with WAIT_CYCLES=2 unless stated otherwise:
  Fetch: if_req, if_addr=0x8000_0010 -> if_gnt same cycle; sram_addr=0x00004 and oe_n=0 for 2 cycles; if_ack 3 cycles after the grant with if_rdata equal to the model word.
  Store: d_req, d_we=1, d_be=4'b0011, d_addr=0x8000_0104, d_wdata=0xDEAD_BEEF -> we_n=0, be_n=4'b1100, wdata_oe=1 for 2 cycles; a subsequent load of the same address returns 0x????_BEEF, with the upper half unchanged.
  Collision: if_req and d_req rise in the same cycle -> d_gnt first; if_gnt exactly 4 cycles later; no cycle has both grants high.
  Reset: rst asserted during the second I_ACC cycle -> next cycle ce_n=1, busy=0, no if_ack; a fresh fetch then completes normally.
  Timing sweep: WAIT_CYCLES=1 and 7 -> ack latency 2 and 8 cycles respectively; back-to-back fetches spaced WAIT_CYCLES+2 cycles apart.
  Hold: if_req held high across an ack -> a second grant occurs and d_rdata stays unchanged throughout.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared CPU package for the SRAM arbiter: FSM states, access bundle and SRAM
// control encoding.
package sram_arbiter_pkg;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int SRAM_AW         = 20;
  localparam int CNT_W           = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Everything latched at grant time; the requester may change its inputs afterwards.
  typedef struct packed {
    logic               is_d;
    logic               we;
    logic [3:0]         be;
    logic [SRAM_AW-1:0] addr;
    logic [31:0]        wdata;
  } acc_req_t;

  typedef struct packed {
    logic       ce_n;
    logic       oe_n;
    logic       we_n;
    logic [3:0] be_n;
    logic       wdata_oe;
  } sram_ctl_t;

  localparam sram_ctl_t SRAM_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                      be_n: 4'hF, wdata_oe: 1'b0};

  function automatic logic [SRAM_AW-1:0] word_addr(input logic [31:0] a);
    return a[SRAM_AW+1:2];
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// CPU-side request ports and SRAM pin bundle seen by the arbiter.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic               if_req;
  logic [31:0]        if_addr;
  logic               if_gnt;
  logic               if_ack;
  logic [31:0]        if_rdata;

  logic               d_req;
  logic               d_we;
  logic [3:0]         d_be;
  logic [31:0]        d_addr;
  logic [31:0]        d_wdata;
  logic               d_gnt;
  logic               d_ack;
  logic [31:0]        d_rdata;

  logic               busy;

  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               sram_we_n;
  logic [3:0]         sram_be_n;
  logic [31:0]        sram_wdata;
  logic               sram_wdata_oe;
  logic [31:0]        sram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_rdata,
    output if_gnt, if_ack, if_rdata, d_gnt, d_ack, d_rdata, busy,
           sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
           sram_wdata, sram_wdata_oe
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, sram_rdata,
    input  if_gnt, if_ack, if_rdata, d_gnt, d_ack, d_rdata, busy,
           sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
           sram_wdata, sram_wdata_oe
  );

endinterface

// File: rtl/sram_arbiter_wait_counter.sv
// Access wait-state down-counter: load at grant, count down during the access,
// flag zero on the last access cycle.
module arb_wait_counter
  import sram_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (fetch/data) arbiter onto one asynchronous SRAM; data has fixed
// priority and every access holds the bus for WAIT_CYCLES cycles.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  arb_state_e       state, nxt;
  acc_req_t         acc;
  sram_ctl_t        ctl;
  logic [CNT_W-1:0] cnt;
  logic             zero;
  logic             in_acc;
  logic             d_gnt, if_gnt;
  logic [31:0]      if_rdata_q, d_rdata_q;

  assign in_acc = (state == D_ACC) || (state == I_ACC);

  arb_wait_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (d_gnt | if_gnt),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .dec      (in_acc),
    .cnt      (cnt),
    .zero     (zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:         if (d_gnt) nxt = D_ACC; else if (if_gnt) nxt = I_ACC;
      D_ACC, I_ACC: if (zero) nxt = DONE;
      DONE:         nxt = IDLE;
      default:      nxt = IDLE;
    endcase
  end

  // Outputs: grants, acks, busy and SRAM controls
  always_comb begin
    d_gnt      = 1'b0;
    if_gnt     = 1'b0;
    bus.d_ack  = 1'b0;
    bus.if_ack = 1'b0;
    bus.busy   = (state != IDLE);
    ctl        = SRAM_IDLE;
    case (state)
      IDLE: if (!rst) begin
        d_gnt  = bus.d_req;
        if_gnt = bus.if_req & ~bus.d_req;
      end
      D_ACC, I_ACC: begin
        ctl.ce_n = 1'b0;
        ctl.be_n = ~acc.be;
        if (acc.we && state == D_ACC) begin
          ctl.we_n     = 1'b0;
          ctl.wdata_oe = 1'b1;
        end else begin
          ctl.oe_n     = 1'b0;
        end
      end
      DONE: begin
        bus.d_ack  = acc.is_d;
        bus.if_ack = ~acc.is_d;
      end
      default: ;
    endcase
  end

  // Request latch; sram_addr/sram_wdata come straight from here so they hold between accesses.
  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (d_gnt)
      acc <= '{is_d: 1'b1, we: bus.d_we, be: bus.d_be,
               addr: word_addr(bus.d_addr), wdata: bus.d_wdata};
    else if (if_gnt)
      acc <= '{is_d: 1'b0, we: 1'b0, be: 4'hF,
               addr: word_addr(bus.if_addr), wdata: '0};
  end

  // Read data is captured on the last access cycle, per port; stores leave d_rdata alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (in_acc && zero) begin
      if (acc.is_d && !acc.we) d_rdata_q  <= bus.sram_rdata;
      else if (!acc.is_d)      if_rdata_q <= bus.sram_rdata;
    end
  end

  assign bus.d_gnt         = d_gnt;
  assign bus.if_gnt        = if_gnt;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.sram_addr     = acc.addr;
  assign bus.sram_wdata    = acc.wdata;
  assign bus.sram_ce_n     = ctl.ce_n;
  assign bus.sram_oe_n     = ctl.oe_n;
  assign bus.sram_we_n     = ctl.we_n;
  assign bus.sram_be_n     = ctl.be_n;
  assign bus.sram_wdata_oe = ctl.wdata_oe;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic against a
// word-level memory model; extra instances cover WAIT_CYCLES=1 and 7.
module tb_sram_arbiter;

  logic clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
  int   cyc = 0, vecs = 0, errs = 0;
  logic [31:0] mem0    [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_d = '0, exp_i = '0;

  sram_arbiter_if b0 ();
  sram_arbiter_if b1 ();
  sram_arbiter_if b7 ();

  sram_arbiter #(.WAIT_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  sram_arbiter #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  sram_arbiter #(.WAIT_CYCLES(7)) u_dut7 (.clk(clk), .rst(rst), .bus(b7));

  function automatic logic [31:0] init_word(input logic [19:0] a);
    return ({12'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Random byte address within the 256-word model window; junk in [31:22] and [1:0].
  function automatic logic [31:0] rand_addr();
    return {10'($urandom), 12'h0, 8'($urandom), 2'($urandom)};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: b0 is a writable 256-word array, b1/b7 are read-only pattern ROMs.
  assign b0.sram_rdata = b0.sram_oe_n ? ~mem0[b0.sram_addr[7:0]] : mem0[b0.sram_addr[7:0]];
  assign b1.sram_rdata = init_word(b1.sram_addr);
  assign b7.sram_rdata = init_word(b7.sram_addr);

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem0[i] <= init_word(20'(i));
    end else if (!b0.sram_ce_n && !b0.sram_we_n && b0.sram_wdata_oe) begin
      for (int k = 0; k < 4; k++)
        if (!b0.sram_be_n[k]) mem0[b0.sram_addr[7:0]][8*k +: 8] <= b0.sram_wdata[8*k +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    b0.if_req = 0; b0.if_addr = 0; b0.d_req = 0; b0.d_we = 0; b0.d_be = 0; b0.d_addr = 0; b0.d_wdata = 0;
    b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_be = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b7.if_req = 0; b7.if_addr = 0; b7.d_req = 0; b7.d_we = 0; b7.d_be = 0; b7.d_addr = 0; b7.d_wdata = 0;
  endtask

  // Drives one access on b0 and records what was observed; comparisons are done by the caller.
  // ctl = {sram_addr, oe_n, we_n, wdata_oe, be_n} from the first cycle with ce_n low.
  task automatic access(input logic is_d, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int gnt_cyc, output int ack_cyc, output logic [31:0] rdata,
                        output int acc_n, output logic [26:0] ctl, output logic stable);
    logic [26:0] s;
    gnt_cyc = -1; ack_cyc = -1; acc_n = 0; stable = 1'b1; rdata = '0; ctl = '0;
    if (is_d) begin b0.d_req = 1; b0.d_we = we; b0.d_be = be; b0.d_addr = addr; b0.d_wdata = wdata; end
    else begin b0.if_req = 1; b0.if_addr = addr; end
    for (int t = 0; t < 30 && ack_cyc < 0; t++) begin
      #1;
      if (gnt_cyc < 0 && (is_d ? b0.d_gnt : b0.if_gnt)) gnt_cyc = cyc;
      if (!b0.sram_ce_n) begin
        s = {b0.sram_addr, b0.sram_oe_n, b0.sram_we_n, b0.sram_wdata_oe, b0.sram_be_n};
        if (acc_n == 0) ctl = s; else if (s !== ctl) stable = 1'b0;
        acc_n++;
      end
      if (is_d ? b0.d_ack : b0.if_ack) begin
        ack_cyc = cyc;
        rdata = is_d ? b0.d_rdata : b0.if_rdata;
      end
      tick();
      if (gnt_cyc >= 0) begin
        b0.d_req = 0; b0.if_req = 0;
        b0.d_addr = $urandom; b0.if_addr = $urandom; b0.d_wdata = $urandom; b0.d_be = 4'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; mem_init = 1;
    b0.if_req = 1; b0.d_req = 1;
    tick(); tick(); #1;
    vecs++; if ({b0.d_gnt, b0.if_gnt} !== 2'b00) begin errs++; $display("FAIL reset_gnt: got %b want 00", {b0.d_gnt, b0.if_gnt}); end
    vecs++; if ({b0.busy, b0.sram_ce_n, b0.sram_oe_n, b0.sram_we_n, b0.sram_be_n, b0.sram_wdata_oe, b0.if_ack, b0.d_ack} !== 11'b0_111_1111_0_00) begin
      errs++; $display("FAIL reset_ctl: got %b want 01111111000", {b0.busy, b0.sram_ce_n, b0.sram_oe_n, b0.sram_we_n, b0.sram_be_n, b0.sram_wdata_oe, b0.if_ack, b0.d_ack}); end
    vecs++; if (b0.sram_addr !== 20'h0) begin errs++; $display("FAIL reset_addr: got %h want 00000", b0.sram_addr); end
    vecs++; if ({b0.if_rdata, b0.d_rdata} !== 64'h0) begin errs++; $display("FAIL reset_rdata: got %h/%h want 0/0", b0.if_rdata, b0.d_rdata); end
    b0.if_req = 0; b0.d_req = 0;
    rst = 0; mem_init = 0;
    tick();
    exp_d = '0; exp_i = '0;
  endtask

  task automatic test_fetch();
    int g, a, n, start; logic [31:0] rd; logic [26:0] c; logic st;
    start = cyc;
    access(0, 0, 4'hF, 32'h8000_0010, 0, g, a, rd, n, c, st);
    vecs++; if (g !== start) begin errs++; $display("FAIL fetch_gnt_cycle: got %0d want %0d", g, start); end
    vecs++; if (n !== 2) begin errs++; $display("FAIL fetch_acc_cycles: got %0d want 2", n); end
    vecs++; if (c !== {20'h00004, 1'b0, 1'b1, 1'b0, 4'h0}) begin errs++; $display("FAIL fetch_ctl: got %h want %h", c, {20'h00004, 1'b0, 1'b1, 1'b0, 4'h0}); end
    vecs++; if (st !== 1'b1) begin errs++; $display("FAIL fetch_ctl_stable: got %b want 1", st); end
    vecs++; if (a - g !== 3) begin errs++; $display("FAIL fetch_latency: got %0d want 3", a - g); end
    exp_i = ref_mem[4];
    vecs++; if (rd !== exp_i) begin errs++; $display("FAIL fetch_rdata: got %h want %h", rd, exp_i); end
  endtask

  task automatic test_store();
    int g, a, n; logic [31:0] rd, upper_orig; logic [26:0] c; logic st;
    upper_orig = ref_mem[8'h41];
    access(1, 1, 4'b0011, 32'h8000_0104, 32'hDEAD_BEEF, g, a, rd, n, c, st);
    vecs++; if (c !== {20'h00041, 1'b1, 1'b0, 1'b1, 4'b1100}) begin errs++; $display("FAIL store_ctl: got %h want %h", c, {20'h00041, 1'b1, 1'b0, 1'b1, 4'b1100}); end
    vecs++; if (n !== 2 || st !== 1'b1) begin errs++; $display("FAIL store_acc_cycles: got %0d/%b want 2/1", n, st); end
    vecs++; if (a - g !== 3) begin errs++; $display("FAIL store_latency: got %0d want 3", a - g); end
    vecs++; if (rd !== exp_d) begin errs++; $display("FAIL store_d_rdata_kept: got %h want %h", rd, exp_d); end
    ref_mem[8'h41][15:0] = 16'hBEEF;
    access(1, 0, 4'hF, 32'h8000_0104, 0, g, a, rd, n, c, st);
    exp_d = ref_mem[8'h41];
    vecs++; if (rd !== {upper_orig[31:16], 16'hBEEF}) begin errs++; $display("FAIL store_readback: got %h want %h", rd, {upper_orig[31:16], 16'hBEEF}); end
    vecs++; if (c !== {20'h00041, 1'b0, 1'b1, 1'b0, 4'h0}) begin errs++; $display("FAIL load_ctl: got %h want %h", c, {20'h00041, 1'b0, 1'b1, 1'b0, 4'h0}); end
  endtask

  task automatic test_collision();
    int dg, ig, ia, both, start; logic [31:0] da, fa, drd, ird;
    da = rand_addr(); fa = rand_addr();
    dg = -1; ig = -1; ia = -1; both = 0; drd = '0; ird = '0;
    start = cyc;
    b0.d_req = 1; b0.d_we = 0; b0.d_be = 4'hF; b0.d_addr = da;
    b0.if_req = 1; b0.if_addr = fa;
    for (int t = 0; t < 30 && ia < 0; t++) begin
      #1;
      if (b0.d_gnt && b0.if_gnt) both++;
      if (b0.d_gnt && dg < 0) dg = cyc;
      if (b0.if_gnt && ig < 0) ig = cyc;
      if (b0.d_ack) drd = b0.d_rdata;
      if (b0.if_ack) begin ia = cyc; ird = b0.if_rdata; end
      tick();
      if (dg >= 0) b0.d_req = 0;
      if (ig >= 0) b0.if_req = 0;
    end
    b0.d_req = 0; b0.if_req = 0;
    vecs++; if (dg !== start) begin errs++; $display("FAIL coll_d_first: got %0d want %0d", dg, start); end
    vecs++; if (ig - dg !== 4) begin errs++; $display("FAIL coll_if_gap: got %0d want 4", ig - dg); end
    vecs++; if (both !== 0) begin errs++; $display("FAIL coll_both_gnt: got %0d want 0", both); end
    exp_d = ref_mem[da[9:2]]; exp_i = ref_mem[fa[9:2]];
    vecs++; if (drd !== exp_d) begin errs++; $display("FAIL coll_d_rdata: got %h want %h", drd, exp_d); end
    vecs++; if (ird !== exp_i || ia - ig !== 3) begin errs++; $display("FAIL coll_if_ack: got %h@%0d want %h@3", ird, ia - ig, exp_i); end
  endtask

  task automatic test_reset_mid();
    int acks, g, a, n; logic [31:0] rd, fa; logic [26:0] c; logic st;
    b0.if_req = 1; b0.if_addr = rand_addr();
    tick(); b0.if_req = 0;
    tick(); #1;
    vecs++; if (b0.sram_ce_n !== 1'b0) begin errs++; $display("FAIL rstmid_in_acc: got ce_n %b want 0", b0.sram_ce_n); end
    rst = 1;
    tick(); rst = 0; #1;
    vecs++; if ({b0.sram_ce_n, b0.busy, b0.if_ack} !== 3'b100) begin errs++; $display("FAIL rstmid_abort: got %b want 100", {b0.sram_ce_n, b0.busy, b0.if_ack}); end
    acks = 0;
    for (int t = 0; t < 6; t++) begin tick(); #1; if (b0.if_ack || b0.d_ack) acks++; end
    vecs++; if (acks !== 0) begin errs++; $display("FAIL rstmid_no_ack: got %0d want 0", acks); end
    exp_i = '0; exp_d = '0;
    vecs++; if ({b0.if_rdata, b0.d_rdata} !== 64'h0) begin errs++; $display("FAIL rstmid_rdata: got %h/%h want 0/0", b0.if_rdata, b0.d_rdata); end
    fa = rand_addr();
    tick();
    access(0, 0, 4'hF, fa, 0, g, a, rd, n, c, st);
    exp_i = ref_mem[fa[9:2]];
    vecs++; if (rd !== exp_i || a - g !== 3) begin errs++; $display("FAIL rstmid_refetch: got %h@%0d want %h@3", rd, a - g, exp_i); end
  endtask

  task automatic test_random();
    int g, a, n, start, op; logic [31:0] rd, ad, wd, exp; logic [3:0] be; logic [26:0] c; logic st;
    logic [6:0] exp_ctl;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2); ad = rand_addr(); wd = $urandom; be = 4'($urandom);
      start = cyc;
      access(op != 0, op == 2, be, ad, wd, g, a, rd, n, c, st);
      case (op)
        0: begin exp_i = ref_mem[ad[9:2]]; exp = exp_i; exp_ctl = {3'b010, 4'h0}; end
        1: begin exp_d = ref_mem[ad[9:2]]; exp = exp_d; exp_ctl = {3'b010, ~be}; end
        default: begin
          exp = exp_d; exp_ctl = {3'b101, ~be};
          for (int k = 0; k < 4; k++) if (be[k]) ref_mem[ad[9:2]][8*k +: 8] = wd[8*k +: 8];
        end
      endcase
      vecs++; if (g !== start || a - g !== 3) begin errs++; $display("FAIL rand%0d_timing op%0d: got gnt+%0d ack+%0d want +0 +3", i, op, g - start, a - g); end
      vecs++; if (c[26:7] !== ad[21:2]) begin errs++; $display("FAIL rand%0d_addr: got %h want %h", i, c[26:7], ad[21:2]); end
      vecs++; if (c[6:0] !== exp_ctl || n !== 2) begin errs++; $display("FAIL rand%0d_ctl op%0d: got %b/%0d want %b/2", i, op, c[6:0], n, exp_ctl); end
      vecs++; if (rd !== exp) begin errs++; $display("FAIL rand%0d_rdata op%0d: got %h want %h", i, op, rd, exp); end
    end
  endtask

  task automatic test_hold();
    int g1, g2, a2, chg; logic [31:0] fa, rd;
    g1 = -1; g2 = -1; a2 = -1; chg = 0; rd = '0;
    fa = rand_addr();
    b0.if_req = 1; b0.if_addr = fa;
    for (int t = 0; t < 30 && a2 < 0; t++) begin
      #1;
      if (b0.d_rdata !== exp_d) chg++;
      if (b0.if_gnt) begin if (g1 < 0) g1 = cyc; else if (g2 < 0) g2 = cyc; end
      if (b0.if_ack && g2 >= 0) begin a2 = cyc; rd = b0.if_rdata; end
      tick();
      if (g2 >= 0) b0.if_req = 0;
    end
    b0.if_req = 0;
    vecs++; if (g2 - g1 !== 4 || g1 < 0) begin errs++; $display("FAIL hold_regrant: got gap %0d want 4", g2 - g1); end
    vecs++; if (chg !== 0) begin errs++; $display("FAIL hold_d_rdata: got %0d changed cycles want 0", chg); end
    exp_i = ref_mem[fa[9:2]];
    vecs++; if (rd !== exp_i) begin errs++; $display("FAIL hold_if_rdata: got %h want %h", rd, exp_i); end
  endtask

  task automatic test_sweep();
    int g1a, g2a, a1a, g1b, g2b, a1b; logic [31:0] fa1, fa7, r1, r7;
    g1a = -1; g2a = -1; a1a = -1; g1b = -1; g2b = -1; a1b = -1; r1 = '0; r7 = '0;
    fa1 = $urandom; fa7 = $urandom;
    b1.if_req = 1; b1.if_addr = fa1;
    b7.if_req = 1; b7.if_addr = fa7;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (b1.if_gnt) begin if (g1a < 0) g1a = cyc; else if (g2a < 0) g2a = cyc; end
      if (b7.if_gnt) begin if (g1b < 0) g1b = cyc; else if (g2b < 0) g2b = cyc; end
      if (b1.if_ack && a1a < 0) begin a1a = cyc; r1 = b1.if_rdata; end
      if (b7.if_ack && a1b < 0) begin a1b = cyc; r7 = b7.if_rdata; end
      tick();
      if (g2a >= 0) b1.if_req = 0;
      if (g2b >= 0) b7.if_req = 0;
    end
    vecs++; if (a1a - g1a !== 2 || g1a < 0) begin errs++; $display("FAIL sweep1_latency: got %0d want 2", a1a - g1a); end
    vecs++; if (g2a - g1a !== 3) begin errs++; $display("FAIL sweep1_spacing: got %0d want 3", g2a - g1a); end
    vecs++; if (r1 !== init_word(fa1[21:2])) begin errs++; $display("FAIL sweep1_rdata: got %h want %h", r1, init_word(fa1[21:2])); end
    vecs++; if (a1b - g1b !== 8 || g1b < 0) begin errs++; $display("FAIL sweep7_latency: got %0d want 8", a1b - g1b); end
    vecs++; if (g2b - g1b !== 9) begin errs++; $display("FAIL sweep7_spacing: got %0d want 9", g2b - g1b); end
    vecs++; if (r7 !== init_word(fa7[21:2])) begin errs++; $display("FAIL sweep7_rdata: got %h want %h", r7, init_word(fa7[21:2])); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(20'(i));
    idle_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_collision();
    test_random();
    test_hold();
    test_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
